uart_cmd_frame_tx: RTL and testbench

//   Initiator for the badge UART command-frame protocol. Builds frame {mode, payload[0..N-1], mode}
//   and serialises it 8N1 on a single TX line toward a peer badge's command parser.

---
 rtl/uart_cmd_frame_tx_pkg.sv | 40 ++++
 rtl/uart_tx_byte.sv | 72 +++++++
 rtl/uart_cmd_frame_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_cmd_frame_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_frame_tx_pkg.sv
//------------------------------------------------------------------------------
// uart_cmd_frame_tx_pkg
//   Shared definitions for the badge UART command-frame initiator:
//   command mode byte constants, frame FSM state encoding and the payload
//   length clamp helper.
//   Optional feature macro used by the importing modules: CMD_TX_IDLE_GAP_EN.
//------------------------------------------------------------------------------
package uart_cmd_frame_tx_pkg;

   // Mode bytes understood by the peer badge command parser
   localparam logic [7:0] CMD_SHOOTING_FLAGS = 8'h41;  // 'A'
   localparam logic [7:0] CMD_HORNET_KEY     = 8'h40;  // '@'
   localparam logic [7:0] CMD_AES_KEY        = 8'h42;  // 'B'
   localparam logic [7:0] CMD_AES_PT         = 8'h43;  // 'C'
   localparam logic [7:0] CMD_AES_ENC        = 8'h44;  // 'D'
   localparam logic [7:0] CMD_AES_DEC        = 8'h45;  // 'E'
   localparam logic [7:0] CMD_FLAG_RESET     = 8'h60;  // '`'

   // Frame sequencer states. Byte loading has no state of its own: the next
   // byte is handed to the serializer on the same edge that retires the
   // previous stop bit, so bytes go out back-to-back.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } frame_state_e;

   // Saturate a requested payload length to the configured maximum.
   function automatic logic [4:0] clamp_len(input logic [4:0] len,
                                            input int unsigned max_len);
      logic [4:0] max5;
      if (max_len >= 31) begin
         return len;
      end
      max5 = 5'(max_len);
      return (len > max5) ? max5 : len;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
//------------------------------------------------------------------------------
// uart_tx_byte
//   Byte-level 8N1 serializer: start bit (0), 8 data bits LSB first, stop bit
//   (1), each held for exactly BAUD_DIV clock cycles. A new byte may be
//   started in the final cycle of the current stop bit (done=1), giving
//   gap-free back-to-back bytes.
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset (tx forced high)
//   start    in   load data and begin the start bit next cycle (when ready)
//   data     in   byte to send
//   ready    out  idle, or in the last stop-bit cycle
//   done     out  last cycle of the stop bit
//   tx       out  serial line, idle high
//------------------------------------------------------------------------------
module uart_tx_byte #(
   parameter int BAUD_DIV = 10764
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       ready,
   output logic       done,
   output logic       tx
);

   localparam int             BW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [3:0]     STOP_BIT  = 4'd9;

   logic          active_reg;
   logic [BW-1:0] baud_cnt_reg;
   logic [3:0]    bit_cnt_reg;   // 0 = start, 1..8 = data, 9 = stop
   logic [8:0]    shift_reg;     // remaining data bits with the stop bit on top
   logic          tx_reg;
   logic          bit_end;

   assign bit_end = active_reg && (baud_cnt_reg == BAUD_LAST);
   assign done    = bit_end && (bit_cnt_reg == STOP_BIT);
   assign ready   = !active_reg || done;
   assign tx      = tx_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_reg   <= 1'b0;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '1;
         tx_reg       <= 1'b1;
      end else if (start && ready) begin
         active_reg   <= 1'b1;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= {1'b1, data};
         tx_reg       <= 1'b0;
      end else if (bit_end) begin
         baud_cnt_reg <= '0;
         if (bit_cnt_reg == STOP_BIT) begin
            // line is already high from the stop bit; just go idle
            active_reg <= 1'b0;
         end else begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            tx_reg      <= shift_reg[0];
            shift_reg   <= {1'b1, shift_reg[8:1]};
         end
      end else if (active_reg) begin
         baud_cnt_reg <= baud_cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_cmd_frame_tx.sv
//------------------------------------------------------------------------------
// uart_cmd_frame_tx
//   Badge UART command-frame initiator. Accepts {mode, len, payload}, then
//   sends mode, payload bytes (MSB byte first), mode again, all 8N1 and
//   back-to-back on tx. Lengths above MAX_PAYLOAD are clamped.
//   Optional macro CMD_TX_IDLE_GAP_EN: hold tx idle for GAP_BITS bit-times
//   after the terminator (busy stays high) before signalling frame_done.
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset; aborts any frame
//   cmd_valid    in   command request, taken when cmd_ready is high
//   cmd_ready    out  idle and able to accept a command
//   cmd_mode     in   mode byte (first and last byte of the frame)
//   cmd_len      in   payload byte count 0..16 (larger values clamped)
//   cmd_payload  in   payload, byte [127:120] sent first
//   tx           out  UART serial out, idle high
//   busy         out  frame bytes (and gap) in progress
//   frame_done   out  one-cycle pulse once the frame has fully gone out
//------------------------------------------------------------------------------
module uart_cmd_frame_tx
   import uart_cmd_frame_tx_pkg::*;
#(
   parameter int BAUD_DIV    = 10764,
   parameter int MAX_PAYLOAD = 16
`ifdef CMD_TX_IDLE_GAP_EN
   ,
   parameter int GAP_BITS    = 2
`endif
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [7:0]   cmd_mode,
   input  logic [4:0]   cmd_len,
   input  logic [127:0] cmd_payload,
   output logic         tx,
   output logic         busy,
   output logic         frame_done
);

   frame_state_e state_reg, state_next;

   logic [7:0]   mode_reg;
   logic [4:0]   len_reg;        // clamped payload length
   logic [127:0] payload_reg;    // next payload byte always sits in [127:120]
   logic [4:0]   byte_idx_reg;   // index of the byte on the line, 0..len+1

   logic         byte_start;
   logic [7:0]   byte_data;
   logic         byte_ready;
   logic         byte_done;
   logic         accept;
   logic         load_payload;

`ifdef CMD_TX_IDLE_GAP_EN
   localparam int GAP_CYCLES = GAP_BITS * BAUD_DIV;
   localparam int GW         = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   logic [GW-1:0] gap_cnt_reg;
`endif

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_tx_byte (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (byte_start),
      .data    (byte_data),
      .ready   (byte_ready),
      .done    (byte_done),
      .tx      (tx)
   );

   assign cmd_ready  = (state_reg == ST_IDLE) && byte_ready;
   assign busy       = (state_reg == ST_SHIFT) || (state_reg == ST_GAP);
   assign frame_done = (state_reg == ST_DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // The first byte comes straight from cmd_mode on the accept edge so the
   // start bit begins the very next cycle.
   always_comb begin
      state_next   = state_reg;
      byte_start   = 1'b0;
      byte_data    = mode_reg;
      accept       = 1'b0;
      load_payload = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept     = 1'b1;
               byte_start = 1'b1;
               byte_data  = cmd_mode;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (byte_done) begin
               if (byte_idx_reg == len_reg + 5'd1) begin
`ifdef CMD_TX_IDLE_GAP_EN
                  state_next = ST_GAP;
`else
                  state_next = ST_DONE;
`endif
               end else begin
                  byte_start = 1'b1;
                  if (byte_idx_reg != len_reg) begin
                     byte_data    = payload_reg[127:120];
                     load_payload = 1'b1;
                  end
               end
            end
         end
         ST_GAP: begin
`ifdef CMD_TX_IDLE_GAP_EN
            if (gap_cnt_reg == GAP_LAST) begin
               state_next = ST_DONE;
            end
`else
            state_next = ST_DONE;
`endif
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_reg     <= '0;
         len_reg      <= '0;
         payload_reg  <= '0;
         byte_idx_reg <= '0;
      end else if (accept) begin
         mode_reg     <= cmd_mode;
         len_reg      <= clamp_len(cmd_len, MAX_PAYLOAD);
         payload_reg  <= cmd_payload;
         byte_idx_reg <= '0;
      end else if (byte_start) begin
         byte_idx_reg <= byte_idx_reg + 5'd1;
         if (load_payload) begin
            payload_reg <= {payload_reg[119:0], 8'h00};
         end
      end
   end

`ifdef CMD_TX_IDLE_GAP_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gap_cnt_reg <= '0;
      end else if (state_reg == ST_GAP) begin
         gap_cnt_reg <= gap_cnt_reg + 1'b1;
      end else begin
         gap_cnt_reg <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
//------------------------------------------------------------------------------
// tb_uart_cmd_frame_tx
//   Directed bench for uart_cmd_frame_tx with BAUD_DIV=4, GAP_BITS=2.
//   Build with or without CMD_TX_IDLE_GAP_EN.
//------------------------------------------------------------------------------
module tb_uart_cmd_frame_tx;

   localparam int BAUD = 4;
`ifdef CMD_TX_IDLE_GAP_EN
   localparam int GAP_CYC = 8;
`else
   localparam int GAP_CYC = 0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [7:0]   cmd_mode = 8'h00;
   logic [4:0]   cmd_len = 5'd0;
   logic [127:0] cmd_payload = '0;
   logic         tx;
   logic         busy;
   logic         frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_bytes [0:17];
   int         exp_n;

   always #5 clk = ~clk;

   uart_cmd_frame_tx #(
      .BAUD_DIV    (BAUD),
      .MAX_PAYLOAD (16)
`ifdef CMD_TX_IDLE_GAP_EN
      ,
      .GAP_BITS    (2)
`endif
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_mode    (cmd_mode),
      .cmd_len     (cmd_len),
      .cmd_payload (cmd_payload),
      .tx          (tx),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Sends one command and checks the line cycle by cycle against exp_bytes.
   // inject_at >= 0 pulses a conflicting command at that frame cycle.
   task automatic run_frame(input string tag, input logic [7:0] mode, input logic [4:0] len,
                            input logic [127:0] pl, input int inject_at);
      logic [9:0] bits;
      int busy_cnt, done_cnt, bad_bits, cyc;
      check($sformatf("%s_ready_pre", tag), 32'(cmd_ready), 32'd1);
      cmd_valid   = 1'b1;
      cmd_mode    = mode;
      cmd_len     = len;
      cmd_payload = pl;
      @(negedge clk);
      // scramble inputs: the frame must come from the latched copy
      cmd_valid   = 1'b0;
      cmd_mode    = 8'hEE;
      cmd_len     = 5'h1F;
      cmd_payload = '1;
      busy_cnt = 0; done_cnt = 0; bad_bits = 0; cyc = 0;
      for (int b = 0; b < exp_n; b++) begin
         bits = '0;
         for (int bi = 0; bi < 10; bi++) begin
            for (int c = 0; c < BAUD; c++) begin
               if (c == 0) bits[bi] = tx;
               else if (tx !== bits[bi]) bad_bits++;
               busy_cnt += int'(busy);
               done_cnt += int'(frame_done);
               if (cyc == inject_at) begin
                  check($sformatf("%s_ready_busy", tag), 32'(cmd_ready), 32'd0);
                  cmd_valid = 1'b1;
                  cmd_mode  = 8'h55;
                  cmd_len   = 5'd3;
               end else begin
                  cmd_valid = 1'b0;
               end
               cyc++;
               @(negedge clk);
            end
         end
         check($sformatf("%s_byte%0d", tag, b), 32'(bits), 32'({1'b1, exp_bytes[b], 1'b0}));
      end
      for (int g = 0; g < GAP_CYC; g++) begin
         if (tx !== 1'b1) bad_bits++;
         busy_cnt += int'(busy);
         done_cnt += int'(frame_done);
         @(negedge clk);
      end
      check($sformatf("%s_bit_stable", tag), 32'(bad_bits), 32'd0);
      check($sformatf("%s_busy_cycles", tag), 32'(busy_cnt), 32'(exp_n * 40 + GAP_CYC));
      check($sformatf("%s_early_done", tag), 32'(done_cnt), 32'd0);
      check($sformatf("%s_done_pulse", tag), {29'd0, frame_done, busy, cmd_ready}, 32'b100);
      check($sformatf("%s_tx_idle", tag), 32'(tx), 32'd1);
      @(negedge clk);
      check($sformatf("%s_done_clear", tag), {29'd0, frame_done, busy, cmd_ready}, 32'b001);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int glitches;
      int done_seen;

      // 1: reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rst_state%0d", i), {28'd0, tx, cmd_ready, busy, frame_done}, 32'b1100);
      end
      reset_n = 1'b1;
      glitches = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) glitches++;
      end
      check("rst_release_glitch", 32'(glitches), 32'd0);
      check("rst_release_ready", 32'(cmd_ready), 32'd1);

      // 2: shooting flags, one payload byte
      exp_n = 3;
      exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h43; exp_bytes[2] = 8'h41;
      run_frame("t2", 8'h41, 5'd1, {8'h43, 120'h0}, -1);

      // 3: AES key, 16 bytes 00..0F
      exp_n = 18;
      exp_bytes[0] = 8'h42;
      for (int i = 0; i < 16; i++) exp_bytes[i+1] = 8'(i);
      exp_bytes[17] = 8'h42;
      run_frame("t3", 8'h42, 5'd16, 128'h000102030405060708090A0B0C0D0E0F, -1);

      // 4a: len 20 clamps to 16
      exp_n = 18;
      exp_bytes = '{8'h43, 8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
                    8'h78, 8'h69, 8'h5A, 8'h4B, 8'h3C, 8'h2D, 8'h1E, 8'h0F, 8'h43};
      run_frame("t4a", 8'h43, 5'd20, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, -1);

      // 4b: len 0 -> mode, mode
      exp_n = 2;
      exp_bytes[0] = 8'h44; exp_bytes[1] = 8'h44;
      run_frame("t4b", 8'h44, 5'd0, 128'hDEADBEEF_00000000_00000000_00000000, -1);

      // 5: conflicting command mid-frame is ignored
      exp_n = 4;
      exp_bytes[0] = 8'h44; exp_bytes[1] = 8'hA5; exp_bytes[2] = 8'h5A; exp_bytes[3] = 8'h44;
      run_frame("t5", 8'h44, 5'd2, {16'hA55A, 112'h0}, 50);

      // 6: reset during data bit 3 of the third byte (41 43 44 41)
      cmd_valid   = 1'b1;
      cmd_mode    = 8'h41;
      cmd_len     = 5'd2;
      cmd_payload = {16'h4344, 112'h0};
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 97; i++) @(negedge clk);
      check("t6_tx_before_abort", {30'd0, tx, busy}, 32'b01);
      reset_n = 1'b0;
      #1;
      check("t6_abort_state", {29'd0, tx, busy, cmd_ready}, 32'b101);
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         done_seen += int'(frame_done);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         done_seen += int'(frame_done);
      end
      check("t6_no_done", 32'(done_seen), 32'd0);
      exp_n = 3;
      exp_bytes[0] = 8'h42; exp_bytes[1] = 8'hAA; exp_bytes[2] = 8'h42;
      run_frame("t6_after", 8'h42, 5'd1, {8'hAA, 120'h0}, -1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
